// File: rtl/noise_pkg.sv
// Shared definitions for the 8-bit LFSR noise generator and its receive-side checker.
// The recurrence and seed must stay identical on both sides of the link.
package noise_pkg;

    localparam logic [7:0] NOISE_SEED = 8'hAA;
    localparam int unsigned RUN_W = 4;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } noise_state_e;

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[1] ^ s[0], s[7:1]};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    // NOTE: sequential state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/noise_checker.sv
// Locks onto an 8-bit LFSR noise stream, then flags and counts mismatching samples.
// A flywheel prediction while locked keeps one corrupted sample from costing two errors.
module noise_checker
    import noise_pkg::*;
#(
    parameter int unsigned LOCK_COUNT   = 4,
    parameter int unsigned UNLOCK_COUNT = 3,
    parameter int unsigned ERR_WIDTH    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           sample_in,
    input  logic                 sample_valid,
    input  logic                 clear_count,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic                 stuck
);

    noise_state_e     state, state_nxt;
    logic [7:0]       prev, prev_nxt;
    logic             have_prev, have_prev_nxt;
    logic [RUN_W-1:0] match_run, match_run_nxt;
    logic [RUN_W-1:0] miss_run, miss_run_nxt;
    logic             err_nxt, stuck_nxt;
    logic [7:0]       predicted;
    logic             match;

    assign predicted = lfsr_next(prev);
    // The all-zero fixed point would self-match forever, so it never counts as a match.
    assign match     = have_prev && (sample_in == predicted) && (sample_in != 8'h00);
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SEARCH;
            prev      <= 8'h00;
            have_prev <= 1'b0;
            match_run <= '0;
            miss_run  <= '0;
            err_pulse <= 1'b0;
            stuck     <= 1'b0;
        end else begin
            state     <= state_nxt;
            prev      <= prev_nxt;
            have_prev <= have_prev_nxt;
            match_run <= match_run_nxt;
            miss_run  <= miss_run_nxt;
            err_pulse <= err_nxt;
            stuck     <= stuck_nxt;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        prev_nxt      = prev;
        have_prev_nxt = have_prev;
        match_run_nxt = match_run;
        miss_run_nxt  = miss_run;
        err_nxt       = 1'b0;
        stuck_nxt     = stuck;

        if (sample_valid) begin
            stuck_nxt = (sample_in == 8'h00);
            unique case (state)
                SEARCH: begin
                    prev_nxt      = sample_in;
                    have_prev_nxt = 1'b1;
                    if (have_prev) begin
                        if (!match) begin
                            match_run_nxt = '0;
                        end else if (match_run == RUN_W'(LOCK_COUNT - 1)) begin
                            state_nxt     = LOCKED;
                            match_run_nxt = '0;
                            miss_run_nxt  = '0;
                        end else begin
                            match_run_nxt = match_run + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (match) begin
                        miss_run_nxt = '0;
                        prev_nxt     = sample_in;
                    end else begin
                        err_nxt = 1'b1;
                        if (miss_run == RUN_W'(UNLOCK_COUNT - 1)) begin
                            state_nxt     = SEARCH;
                            match_run_nxt = '0;
                            miss_run_nxt  = '0;
                            prev_nxt      = sample_in;
                        end else begin
                            miss_run_nxt = miss_run + 1'b1;
                            prev_nxt     = predicted;
                        end
                    end
                end
                default: state_nxt = SEARCH;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (ERR_WIDTH)
    ) u_err_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (err_nxt),
        .clr   (clear_count),
        .count (err_count)
    );

endmodule

// File: tb/tb_noise_checker.sv
// Self-checking bench for noise_checker: directed scenarios followed by a randomized stream,
// all compared against a behavioural model of the lock/flywheel rules.
module tb_noise_checker;

    localparam int LOCK_COUNT   = 4;
    localparam int UNLOCK_COUNT = 3;
    localparam int ERR_WIDTH    = 4;
    localparam int ERR_MAX      = (1 << ERR_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7:0]           sample_in;
    logic                 sample_valid;
    logic                 clear_count;
    logic                 locked;
    logic                 err_pulse;
    logic [ERR_WIDTH-1:0] err_count;
    logic                 stuck;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_prev, m_match_run, m_miss_run, m_count;
    bit m_have, m_locked, m_pulse, m_stuck;

    logic [7:0] g_cur;

    always #5 clk = ~clk;

    noise_checker #(
        .LOCK_COUNT   (LOCK_COUNT),
        .UNLOCK_COUNT (UNLOCK_COUNT),
        .ERR_WIDTH    (ERR_WIDTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clear_count  (clear_count),
        .locked       (locked),
        .err_pulse    (err_pulse),
        .err_count    (err_count),
        .stuck        (stuck)
    );

    function automatic int ref_next(int s);
        return ((s >> 1) | (((s ^ (s >> 1)) & 1) << 7)) & 255;
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_update(bit rst, bit v, int s, bit clr);
        bit is_match;
        if (rst) begin
            m_prev = 0; m_have = 0; m_locked = 0; m_match_run = 0; m_miss_run = 0;
            m_pulse = 0; m_count = 0; m_stuck = 0;
            return;
        end
        m_pulse = 0;
        if (v) begin
            is_match = m_have && (s == ref_next(m_prev)) && (s != 0);
            m_stuck = (s == 0);
            if (!m_locked) begin
                if (m_have) begin
                    m_match_run = is_match ? m_match_run + 1 : 0;
                    if (m_match_run == LOCK_COUNT) begin
                        m_locked = 1; m_match_run = 0; m_miss_run = 0;
                    end
                end
                m_have = 1;
                m_prev = s;
            end else if (is_match) begin
                m_miss_run = 0;
                m_prev = s;
            end else begin
                m_pulse = 1;
                if (m_count < ERR_MAX) m_count++;
                m_miss_run++;
                if (m_miss_run == UNLOCK_COUNT) begin
                    m_locked = 0; m_match_run = 0; m_miss_run = 0; m_prev = s;
                end else begin
                    m_prev = ref_next(m_prev);
                end
            end
        end
        if (clr) m_count = 0;
    endtask

    task automatic step(bit rst, bit v, logic [7:0] s, bit clr);
        @(negedge clk);
        reset = rst; sample_valid = v; sample_in = s; clear_count = clr;
        @(posedge clk);
        model_update(rst, v, int'(s), clr);
        #1;
        check("locked",    {31'b0, locked},    {31'b0, m_locked});
        check("err_pulse", {31'b0, err_pulse}, {31'b0, m_pulse});
        check("err_count", 32'(err_count),     32'(m_count));
        check("stuck",     {31'b0, stuck},     {31'b0, m_stuck});
    endtask

    task automatic send_good(int n);
        for (int i = 0; i < n; i++) begin
            g_cur = 8'(ref_next(int'(g_cur)));
            step(1'b0, 1'b1, g_cur, 1'b0);
        end
    endtask

    task automatic send_bad(bit clr);
        g_cur = 8'(ref_next(int'(g_cur)));
        step(1'b0, 1'b1, g_cur ^ 8'h01, clr);
    endtask

    task automatic restart_stream();
        step(1'b1, 1'b0, 8'h00, 1'b0);
        g_cur = 8'hAA;
        step(1'b0, 1'b1, g_cur, 1'b0);
    endtask

    initial begin
        reset = 1'b1; sample_valid = 1'b0; sample_in = 8'h00; clear_count = 1'b0;
        model_update(1'b1, 1'b0, 0, 1'b0);

        // Reset state
        step(1'b1, 1'b0, 8'h00, 1'b0);
        check("rst_locked", {31'b0, locked}, 32'd0);
        check("rst_count", 32'(err_count), 32'd0);

        // Lock on AA D5 EA F5 FA FD
        g_cur = 8'hAA;
        step(1'b0, 1'b1, g_cur, 1'b0);
        send_good(3);
        check("pre_lock_f5", {31'b0, locked}, 32'd0);
        check("seq_f5", 32'(g_cur), 32'hF5);
        send_good(1);
        check("lock_after_fa", {31'b0, locked}, 32'd1);
        send_good(1);

        // Single corrupted sample costs exactly one error
        send_bad(1'b0);
        check("single_pulse", {31'b0, err_pulse}, 32'd1);
        send_good(1);
        check("flywheel_ok", {31'b0, err_pulse}, 32'd0);
        check("single_count", 32'(err_count), 32'd1);
        check("single_locked", {31'b0, locked}, 32'd1);

        // Three consecutive errors unlock; relock after four correct transitions
        step(1'b0, 1'b0, 8'h00, 1'b1);
        send_bad(1'b0);
        send_bad(1'b0);
        check("unlock_hold", {31'b0, locked}, 32'd1);
        send_bad(1'b0);
        check("unlock_fall", {31'b0, locked}, 32'd0);
        check("unlock_pulse", {31'b0, err_pulse}, 32'd1);
        check("unlock_count", 32'(err_count), 32'd3);
        send_good(4);
        check("relock_pending", {31'b0, locked}, 32'd0);
        send_good(1);
        check("relock", {31'b0, locked}, 32'd1);

        // All-zero stream
        step(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
        check("zero_stuck", {31'b0, stuck}, 32'd1);
        check("zero_unlocked", {31'b0, locked}, 32'd0);
        check("zero_count", 32'(err_count), 32'd0);

        // Valid gaps while locked, then clear coincident with a mismatch
        restart_stream();
        send_good(5);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'($urandom), 1'b0);
        send_good(1);
        check("gap_locked", {31'b0, locked}, 32'd1);
        check("gap_count", 32'(err_count), 32'd0);
        send_bad(1'b0);
        send_good(1);
        send_bad(1'b1);
        check("clr_wins", 32'(err_count), 32'd0);
        check("clr_pulse", {31'b0, err_pulse}, 32'd1);
        send_good(1);

        // Saturation at ERR_WIDTH=4
        for (int i = 0; i < 20; i++) begin
            send_bad(1'b0);
            send_good(1);
        end
        check("saturate", 32'(err_count), 32'hF);

        // Reset mid-stream, relock takes five samples
        step(1'b1, 1'b1, 8'h5C, 1'b0);
        check("midrst_locked", {31'b0, locked}, 32'd0);
        check("midrst_count", 32'(err_count), 32'd0);
        send_good(4);
        check("midrst_pending", {31'b0, locked}, 32'd0);
        send_good(1);
        check("midrst_relock", {31'b0, locked}, 32'd1);

        // Randomized stream
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2)       step(1'b1, 1'($urandom), 8'($urandom), 1'b0);
            else if (r < 15) step(1'b0, 1'b0, 8'($urandom), 1'($urandom_range(0, 9) == 0));
            else if (r < 22) send_bad(1'($urandom_range(0, 9) == 0));
            else if (r < 24) step(1'b0, 1'b1, 8'h00, 1'b0);
            else if (r < 25) begin
                g_cur = 8'($urandom_range(1, 255));
                step(1'b0, 1'b1, g_cur, 1'b0);
            end else if (r < 27) begin
                g_cur = 8'(ref_next(int'(g_cur)));
                step(1'b0, 1'b1, g_cur, 1'b1);
            end else send_good(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_checker.md
# noise_checker

Receive-side checker for the 8-bit LFSR noise stream produced by the noise generator. It accepts samples, predicts each next sample from the previous one using the generator's recurrence, and locks onto the sequence once enough consecutive predictions match. While locked it flags and counts mismatches. It sits in the audio test path and on the bench, downstream of the noise source or any link that carries noise samples.

## Interface
- LOCK_COUNT, 4, consecutive matches in SEARCH required to enter LOCKED (1..15)
- UNLOCK_COUNT, 3, consecutive mismatches in LOCKED that force a return to SEARCH (1..15)
- ERR_WIDTH, 16, width of the error counter
- clk  input  1  system clock; all logic on posedge
- reset  input  1  synchronous, active-high reset
- sample_in  input  8  noise sample under test
- sample_valid  input  1  sample_in is valid this cycle; no backpressure
- clear_count  input  1  synchronous clear of err_count
- locked  output  1  high while in LOCKED
- err_pulse  output  1  one-cycle pulse per mismatch accepted in LOCKED
- err_count  output  ERR_WIDTH  saturating mismatch count
- stuck  output  1  last accepted sample was 8'h00, the LFSR fixed point

## Operation
- Prediction: next(s) = {s[1]^s[0], s[7:1]}.
- Registers: prev (8), have_prev, state, match_run, miss_run, plus the outputs.
- Only cycles with sample_valid high change state. Otherwise everything holds, except err_pulse, which is 0.
- match = have_prev && sample_in == next(prev) && sample_in != 0.
- SEARCH:
  - First valid sample sets have_prev=1 and prev=sample_in.
  - Afterwards, on match: match_run++. When match_run reaches LOCK_COUNT, go to LOCKED, miss_run=0.
  - On mismatch: match_run=0.
  - prev=sample_in always.
  - No err_pulse and no counting in SEARCH.
- LOCKED:
  - On match: miss_run=0, prev=sample_in.
  - On mismatch: err_pulse=1, err_count+1 (saturating at all-ones), miss_run++. prev=next(prev) (flywheel), so a single corrupted sample costs exactly one error.
  - When miss_run reaches UNLOCK_COUNT: go to SEARCH, match_run=0, prev=sample_in.
- stuck updates on every valid sample: 1 iff sample_in==0.
- Simultaneous clear_count and error: clear wins, err_count=0. err_pulse still asserts.
- Reset, including mid-stream: state=SEARCH, have_prev=0, prev=0, both runs 0. Outputs locked=0, err_pulse=0, err_count=0, stuck=0.

## Timing
- All outputs are registered. A sample accepted at edge N is reflected on locked, err_pulse, err_count and stuck after edge N.
- Lock latency: LOCK_COUNT+1 valid samples from reset or unlock. locked rises the cycle after the LOCK_COUNT-th matching sample is accepted.
- Unlock latency: locked falls the cycle after the UNLOCK_COUNT-th consecutive mismatch is accepted. err_pulse is high in that same cycle.
- Gaps in sample_valid of any length do not affect matching; prediction is per accepted sample, not per clock.
- One sample per clock is sustained; there is no throughput limit.

## Structure
- noise_pkg holds:
  - function lfsr_next(8-bit) and constant NOISE_SEED = 8'hAA, shared with the generator
  - state enum {SEARCH, LOCKED}
- Sub-module sat_counter (parameter WIDTH; inc, clr with clr priority; count output) implements err_count.
- All other logic lives in noise_checker.

## Test plan
- Reset, then stream AA, D5, EA, F5, FA, FD, one per cycle -> locked rises the cycle after FA is accepted; err_count=0; err_pulse is never high.
- Once locked, replace F5 (the value following EA) with F4, then continue with the correct values -> exactly one err_pulse, err_count=1, locked stays 1. The next correct sample matches via the flywheel.
- Once locked, send 3 consecutive wrong values -> 3 err_pulses, err_count=3, locked falls after the 3rd. Four more correct transitions relock.
- Send 00, 00, 00, … -> stuck=1, locked never rises, err_count=0.
- Drive sample_valid=0 for 10 cycles between D5 and EA while locked -> no error, locked stays 1. Assert clear_count in the same cycle as a mismatch -> err_count=0, err_pulse=1.
- With ERR_WIDTH=4, force 20 errors by repeatedly relocking and corrupting -> err_count saturates at 4'hF. Assert reset mid-stream -> all outputs 0 the next cycle and relock requires 5 samples.
